sync_fifo_ctrl: RTL and testbench

Single-clock, parametrised FIFO that combines storage and control in one block. It generalises the existing dual-port FIFO memory in four ways: arbitrary non-power-of-two depth, a registered read port with a valid strobe, programmable half-full and half-empty thresholds, and sticky overflow/underflow error flags. It is used as the same-domain buffer behind the async FIFO, and as a stand-alone scoreboard buffer in the UVM environment.

---
 rtl/sync_fifo_ctrl.sv | 130 +++++++++++++
 tb/tb_sync_fifo_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - single-clock FIFO with storage, registered read port, thresholds and sticky errors
//
// Purpose: same-domain buffer of DEPTH words of D_Size bits. DEPTH need not be a
// power of two; both pointers wrap DEPTH-1 -> 0 by compare-and-clear. Reads are
// registered (1-clock latency, qualified by rvalid). All status flags are
// registered from the next-state occupancy so they change on the same edge as count.
//
// Ports:
//   clk     in   single clock, all logic on posedge
//   rst     in   asynchronous active-low reset
//   clr     in   synchronous flush, active-high, overrides w_inc/r_inc
//   w_inc   in   write request (accepted when not full)
//   wdata   in   write data
//   r_inc   in   read request (accepted when not empty)
//   rdata   out  registered read data, held when no read is accepted
//   rvalid  out  rdata holds a word popped on the previous edge
//   wfull   out  count == DEPTH
//   rempty  out  count == 0
//   hfull   out  count >= AF_LVL
//   hempty  out  count <= AE_LVL
//   count   out  occupancy 0..DEPTH
//   ovf     out  sticky: write attempted while full
//   udf     out  sticky: read attempted while empty
module sync_fifo_ctrl #(
  parameter int D_Size = 8,
  parameter int DEPTH  = 343,
  parameter int AF_LVL = DEPTH - 8,
  parameter int AE_LVL = 8,
  localparam int A_Size = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              w_inc,
  input  logic [D_Size-1:0] wdata,
  input  logic              r_inc,
  output logic [D_Size-1:0] rdata,
  output logic              rvalid,
  output logic              wfull,
  output logic              rempty,
  output logic              hfull,
  output logic              hempty,
  output logic [A_Size:0]   count,
  output logic              ovf,
  output logic              udf
);

  localparam int CW = A_Size + 1;
  localparam logic [A_Size-1:0] PTR_LAST  = A_Size'(DEPTH - 1);
  localparam logic [CW-1:0]     CNT_FULL  = CW'(DEPTH);
  localparam logic [CW-1:0]     AF_CNT    = CW'(AF_LVL);
  localparam logic [CW-1:0]     AE_CNT    = CW'(AE_LVL);
  localparam logic              HFULL_RST = (AF_LVL == 0);

  logic [D_Size-1:0] mem [DEPTH];

  logic [A_Size-1:0] waddr;
  logic [A_Size-1:0] raddr;
  logic [A_Size-1:0] waddr_nxt;
  logic [A_Size-1:0] raddr_nxt;
  logic [CW-1:0]     count_nxt;
  logic              wr_ok;
  logic              rd_ok;

  // Accepts are judged against the registered (pre-edge) flags; clr blocks both.
  assign wr_ok = w_inc & ~wfull  & ~clr;
  assign rd_ok = r_inc & ~rempty & ~clr;

  // Compare-and-clear wrap keeps addresses below DEPTH for any depth.
  assign waddr_nxt = (waddr == PTR_LAST) ? '0 : waddr + 1'b1;
  assign raddr_nxt = (raddr == PTR_LAST) ? '0 : raddr + 1'b1;

  always_comb begin
    count_nxt = count;
    if (clr) begin
      count_nxt = '0;
    end else if (wr_ok && !rd_ok) begin
      count_nxt = count + CW'(1);
    end else if (rd_ok && !wr_ok) begin
      count_nxt = count - CW'(1);
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waddr  <= '0;
      raddr  <= '0;
      count  <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
      wfull  <= 1'b0;
      rempty <= 1'b1;
      hfull  <= HFULL_RST;
      hempty <= 1'b1;
    end else begin
      count  <= count_nxt;
      wfull  <= (count_nxt == CNT_FULL);
      rempty <= (count_nxt == '0);
      hfull  <= (count_nxt >= AF_CNT);
      hempty <= (count_nxt <= AE_CNT);
      rvalid <= rd_ok;
      if (clr) begin
        waddr <= '0;
        raddr <= '0;
        ovf   <= 1'b0;
        udf   <= 1'b0;
      end else begin
        if (wr_ok) begin
          waddr <= waddr_nxt;
        end
        if (rd_ok) begin
          raddr <= raddr_nxt;
          rdata <= mem[raddr];
        end
        ovf <= ovf | (w_inc & wfull);
        udf <= udf | (r_inc & rempty);
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb/tb_sync_fifo_ctrl.sv - self-checking bench for sync_fifo_ctrl (DEPTH=5, AF_LVL=4, AE_LVL=1)
module tb_sync_fifo_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 5;
  localparam int AF    = 4;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk   = 1'b0;
  logic          rst   = 1'b1;
  logic          clr   = 1'b0;
  logic          w_inc = 1'b0;
  logic          r_inc = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          rvalid, wfull, rempty, hfull, hempty, ovf, udf;
  logic [CW-1:0] count;

  int n_run  = 0;
  int n_fail = 0;

  // Reference model: m_q is the model FIFO; exp_q holds words the DUT must emit.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] exp_q[$];
  int            m_count = 0;
  logic          m_ovf   = 1'b0;
  logic          m_udf   = 1'b0;
  logic          m_rv    = 1'b0;
  logic [DW-1:0] m_last  = '0;
  logic [DW-1:0] mon_exp;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .D_Size(DW),
    .DEPTH (DEPTH),
    .AF_LVL(AF),
    .AE_LVL(AE)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .w_inc (w_inc),
    .wdata (wdata),
    .r_inc (r_inc),
    .rdata (rdata),
    .rvalid(rvalid),
    .wfull (wfull),
    .rempty(rempty),
    .hfull (hfull),
    .hempty(hempty),
    .count (count),
    .ovf   (ovf),
    .udf   (udf)
  );

  // One clock of stimulus; model is updated from pre-edge state. Called at posedge+1.
  task automatic drive(input logic c, input logic w, input logic [DW-1:0] d, input logic r);
    logic wok, rok;
    clr = c; w_inc = w; wdata = d; r_inc = r;
    wok = !c && w && (m_count < DEPTH);
    rok = !c && r && (m_count > 0);
    if (c) begin
      m_q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
      m_udf   = 1'b0;
    end else begin
      if (w && m_count == DEPTH) m_ovf = 1'b1;
      if (r && m_count == 0)     m_udf = 1'b1;
      if (rok) begin
        m_last = m_q.pop_front();
        exp_q.push_back(m_last);
      end
      if (wok) m_q.push_back(d);
      m_count = m_count + int'(wok) - int'(rok);
    end
    @(posedge clk);
    #1;
    if (c) exp_q.delete();
    m_rv  = rok;
    clr   = 1'b0;
    w_inc = 1'b0;
    r_inc = 1'b0;
  endtask

  // Output scoreboard and structural invariants, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      n_run++;
      if (rvalid !== m_rv) begin
        n_fail++;
        $display("FAIL rvalid: got %b expected %b at %0t", rvalid, m_rv, $time);
      end
      if (rvalid === 1'b1) begin
        n_run++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rdata_order: got %h but no word expected at %0t", rdata, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          if (rdata !== mon_exp) begin
            n_fail++;
            $display("FAIL rdata_order: got %h expected %h at %0t", rdata, mon_exp, $time);
          end
        end
      end
      if (int'(count) > DEPTH) begin
        n_fail++;
        $display("FAIL inv_count_max: got %0d expected <= %0d", count, DEPTH);
      end
      if (wfull && rempty) begin
        n_fail++;
        $display("FAIL inv_full_empty: got wfull=1 rempty=1 expected not both");
      end
      if (int'(dut.waddr) >= DEPTH || int'(dut.raddr) >= DEPTH) begin
        n_fail++;
        $display("FAIL inv_ptr_range: got waddr=%0d raddr=%0d expected < %0d", dut.waddr, dut.raddr, DEPTH);
      end
      if (int'(count) != DEPTH &&
          int'(count) != (int'(dut.waddr) - int'(dut.raddr) + DEPTH) % DEPTH) begin
        n_fail++;
        $display("FAIL inv_ptr_count: got count=%0d expected %0d", count,
                 (int'(dut.waddr) - int'(dut.raddr) + DEPTH) % DEPTH);
      end
    end
  end

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    n_run++;
    if ({count, rdata} !== {CW'(0), DW'(0)}) begin
      n_fail++;
      $display("FAIL reset_data: got count=%0d rdata=%h expected 0 0", count, rdata);
    end
    n_run++;
    if ({rvalid, ovf, udf, wfull, rempty, hfull, hempty} !== 7'b0000101) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 0000101",
               {rvalid, ovf, udf, wfull, rempty, hfull, hempty});
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, DW'(8'hA1 + i), 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, '0, 1'b1);
    n_run++;
    if (count !== CW'(0) || rempty !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_drain: got count=%0d rempty=%b expected 0 1", count, rempty);
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    n_run++;
    if (rdata !== 8'hA4 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: got rdata=%h rvalid=%b expected a4 0", rdata, rvalid);
    end
  endtask

  task automatic test_thresholds();
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, 1'b1, DW'(8'h30 + i), 1'b0);
      n_run++;
      if (count !== CW'(i) || hempty !== (i <= AE) || hfull !== (i >= AF) ||
          wfull !== (i == DEPTH) || rempty !== 1'b0) begin
        n_fail++;
        $display("FAIL thresh_%0d: got count=%0d he=%b hf=%b wf=%b re=%b expected %0d %b %b %b 0",
                 i, count, hempty, hfull, wfull, rempty, i, i <= AE, i >= AF, i == DEPTH);
      end
    end
    drive(1'b0, 1'b1, 8'hFF, 1'b0);
    n_run++;
    if (count !== CW'(DEPTH) || ovf !== 1'b1 || wfull !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow: got count=%0d ovf=%b wfull=%b expected %0d 1 1", count, ovf, wfull, DEPTH);
    end
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b0, '0, 1'b1);
    n_run++;
    if (ovf !== m_ovf || rempty !== 1'b1 || hempty !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got ovf=%b rempty=%b hempty=%b expected %b 1 1", ovf, rempty, hempty, m_ovf);
    end
    drive(1'b1, 1'b0, '0, 1'b0);
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 1; i <= 12; i++) drive(1'b0, 1'b1, DW'(i), 1'b1);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    n_run++;
    if (rdata !== 8'h0C || count !== CW'(0)) begin
      n_fail++;
      $display("FAIL wrap_end: got rdata=%h count=%0d expected 0c 0", rdata, count);
    end
    n_run++;
    if (int'(dut.waddr) != 13 % DEPTH || int'(dut.raddr) != 13 % DEPTH) begin
      n_fail++;
      $display("FAIL wrap_ptr: got waddr=%0d raddr=%0d expected %0d", dut.waddr, dut.raddr, 13 % DEPTH);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < DEPTH; i++) drive(1'b0, 1'b1, DW'(8'h10 + i), 1'b0);
    drive(1'b0, 1'b1, 8'h99, 1'b1);
    n_run++;
    if (count !== CW'(DEPTH - 1) || ovf !== 1'b1 || wfull !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_full: got count=%0d ovf=%b wfull=%b expected %0d 1 0", count, ovf, wfull, DEPTH - 1);
    end
    for (int i = 0; i < DEPTH - 1; i++) drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b1, 8'h77, 1'b1);
    n_run++;
    if (count !== CW'(1) || udf !== 1'b1 || rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_empty: got count=%0d udf=%b rvalid=%b expected 1 1 0", count, udf, rvalid);
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic test_clr();
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, DW'(8'h21 + i), 1'b0);
    n_run++;
    if (count !== CW'(3) || ovf !== m_ovf) begin
      n_fail++;
      $display("FAIL clr_setup: got count=%0d ovf=%b expected 3 %b", count, ovf, m_ovf);
    end
    drive(1'b1, 1'b1, 8'hEE, 1'b0);
    n_run++;
    if (count !== CW'(0) || {ovf, udf, rvalid, wfull, rempty, hfull, hempty} !== 7'b0000101) begin
      n_fail++;
      $display("FAIL clr_state: got count=%0d flags=%b expected 0 0000101",
               count, {ovf, udf, rvalid, wfull, rempty, hfull, hempty});
    end
    n_run++;
    if (rdata !== m_last) begin
      n_fail++;
      $display("FAIL clr_rdata_hold: got %h expected %h", rdata, m_last);
    end
    drive(1'b0, 1'b1, 8'h5A, 1'b0);
    n_run++;
    if (count !== CW'(1)) begin
      n_fail++;
      $display("FAIL clr_write: got count=%0d expected 1", count);
    end
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    n_run++;
    if (rdata !== 8'h5A) begin
      n_fail++;
      $display("FAIL clr_readback: got %h expected 5a", rdata);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, DW'(8'h41 + i), 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    n_run++;
    if (count !== CW'(3) || rvalid !== 1'b1 || udf !== 1'b1) begin
      n_fail++;
      $display("FAIL arst_setup: got count=%0d rvalid=%b udf=%b expected 3 1 1", count, rvalid, udf);
    end
    #2 rst = 1'b0;
    m_q.delete();
    exp_q.delete();
    m_count = 0; m_ovf = 1'b0; m_udf = 1'b0; m_rv = 1'b0; m_last = '0;
    #1;
    n_run++;
    if ({count, rdata} !== {CW'(0), DW'(0)} ||
        {rvalid, ovf, udf, wfull, rempty, hfull, hempty} !== 7'b0000101) begin
      n_fail++;
      $display("FAIL arst_async: got count=%0d rdata=%h flags=%b expected 0 00 0000101",
               count, rdata, {rvalid, ovf, udf, wfull, rempty, hfull, hempty});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 8'hC3, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    drive(1'b0, 1'b0, '0, 1'b0);
    n_run++;
    if (rdata !== 8'hC3 || count !== CW'(0)) begin
      n_fail++;
      $display("FAIL arst_resume: got rdata=%h count=%0d expected c3 0", rdata, count);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_thresholds();
    test_wrap();
    test_simultaneous();
    test_clr();
    test_async_reset();
    @(negedge clk);
    n_run++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
